// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared FSM state encoding and default operand width
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// serial_add_ctrl_fa: 1-bit full adder built from two half adders and an OR
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder, one full-adder cell, IDLE/RUN/DONE control
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             fa_s, fa_c, last;

    full_adder_cell u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_c)
    );

    assign last = cnt_q == CW'(WIDTH - 1);

    // next state: abort beats start in IDLE and cancels RUN; DONE always returns to IDLE
    always_comb begin
        state_d = (state_q == IDLE) ? ((start && !abort) ? RUN : IDLE)
                : (state_q == RUN)  ? (abort ? IDLE : (last ? DONE : RUN))
                : IDLE;
    end

    // state, datapath shift registers and registered busy/done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
            if (state_q == IDLE && start && !abort) begin
                a_sr_q  <= a;
                b_sr_q  <= b;
                carry_q <= cin;
                cnt_q   <= '0;
            end
            if (state_q == RUN && !abort) begin
                res_q   <= {fa_s, res_q[WIDTH-1:1]};
                a_sr_q  <= a_sr_q >> 1;
                b_sr_q  <= b_sr_q >> 1;
                carry_q <= fa_c;
                cnt_q   <= cnt_q + CW'(1);
                if (last) begin
                    sum_q  <= {fa_s, res_q[WIDTH-1:1]};
                    cout_q <= fa_c;
                end
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk    input   1      single clock, rising edge
- rst_n  input   1      asynchronous, active-low reset
- start  input   1      request an addition; sampled only in IDLE
- abort  input   1      synchronous cancel of a running addition
- a      input   WIDTH  operand A; sampled with accepted start
- b      input   WIDTH  operand B; sampled with accepted start
- cin    input   1      carry-in; sampled with accepted start
- sum    output  WIDTH  registered result; holds until the next completion
- cout   output  1      registered carry-out; holds until the next completion
- busy   output  1      high in RUN and DONE
- done   output  1      one-cycle pulse when sum/cout update
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder cell, one bit per cycle.
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 IDLE with start=1 at a rising edge SHALL:
- latch a, b into shift registers;
- load the carry flop with cin;
- clear the bit counter to 0;
- go to RUN.
REQ-007 Each RUN cycle SHALL:
- compute s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry);
- shift s into the MSB of the result shift register;
- shift a_sr and b_sr right by one;
- set carry to c;
- increment the counter.
REQ-008 RUN SHALL go to DONE on the edge at which counter==WIDTH-1 is processed; RUN SHALL therefore last exactly WIDTH cycles.
REQ-009 On entry to DONE, sum SHALL be loaded from the result shift register and cout from the carry flop; done SHALL be high for exactly that one DONE cycle.
REQ-010 DONE SHALL always go to IDLE on the next edge.
REQ-011 Latency: done SHALL be high in cycle WIDTH+1, counting the start-accept edge as edge 0.
REQ-012 start in RUN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-013 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted; minimum issue interval is WIDTH+2 cycles.
REQ-014 abort=1 in RUN SHALL return the FSM to IDLE on the next edge; done SHALL NOT pulse and sum/cout SHALL keep their previous values.
REQ-015 abort in IDLE or DONE SHALL have no effect; in IDLE, abort SHALL take priority over start when both are high (start not accepted).
REQ-016 Changes on a, b and cin after the accept edge SHALL NOT affect the result.
REQ-017 busy SHALL be a decode of state (RUN|DONE); done SHALL be a decode of state DONE; both SHALL be glitch-free registered-state decodes.

Reset
REQ-018 rst_n low SHALL immediately force the following, regardless of clk:
- state=IDLE;
- sum=0, cout=0, busy=0, done=0;
- shift registers, carry and counter cleared.
REQ-019 Reset asserted mid-RUN SHALL discard the operation with no done pulse; the first accepted start after deassertion SHALL behave per REQ-006.
REQ-020 Deassertion SHALL be treated as synchronous to clk by the integrating design; the block SHALL accept start on the first edge after deassertion.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding constants (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-022 The 1-bit adder SHALL be a sub-module full_adder_cell, built from two half-adder instances plus an OR for carry, instantiated exactly once.
REQ-023 The counter width SHALL be $clog2(WIDTH) bits.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> done in cycle 9, sum=8'h00, cout=1.
- a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0; then a=8'hA5, b=8'h5A, cin=1 started the cycle after done -> sum=8'h00, cout=1, done at cycle 9 relative to its own accept.
- start re-pulsed at cycles 3 and 9 during a=8'h12+b=8'h34 -> exactly one done, sum=8'h46, busy continuous cycles 1..9.
- abort at cycle 4 of a=8'h0F+b=8'h01 after prior result 8'h46 -> no done, sum stays 8'h46, busy low from cycle 5.
- rst_n low at cycle 5 mid-RUN -> sum=0, cout=0, busy=0 immediately; a subsequent 8'h80+8'h80 -> sum=8'h00, cout=1.
- 1000 random operands/cin with random start/abort -> every done matches a+b+cin of its accepted operands.
